// File: rtl/control_unit_mc.sv
// Multi-cycle control unit: valid/ready fetch, double-operand ALU and jump decode, PC/regbank control.
// Optional CU_RETIRE_CNT_EN adds the retired_cnt output counting retired ALU ops and jumps.
module control_unit_mc #(
  parameter int unsigned INST_W = 16,
  parameter int unsigned REG_AW = 4,
  parameter int unsigned OPC_W  = 5,
  parameter int unsigned OFF_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              inst_valid,
  input  logic [INST_W-1:0] instruction,
  input  logic [3:0]        flags_in,
  output logic              inst_ready,
  output logic              pc_inc,
  output logic              en_pc_2,
  output logic              branch_en,
  output logic [OFF_W-1:0]  pc_offset,
  output logic [REG_AW-1:0] src_reg,
  output logic [REG_AW-1:0] dst_reg,
  output logic [REG_AW-1:0] wr_reg,
  output logic              wr_en,
  output logic [OPC_W-1:0]  op_code,
  output logic              byte_op,
  output logic [5:0]        fsm_state,
  output logic              illegal
`ifdef CU_RETIRE_CNT_EN
  ,
  output logic [31:0]       retired_cnt
`endif
);

  typedef enum logic [5:0] {
    StFetch   = 6'b000001,
    StDecode  = 6'b000010,
    StOperand = 6'b000100,
    StExec    = 6'b001000,
    StWrback  = 6'b010000,
    StJump    = 6'b100000
  } state_e;

  state_e            state;
  logic [INST_W-1:0] ir;
  logic [1:0]        ext_left;
  logic              no_wb;

  logic       imm_src;
  logic [1:0] ext_words;
  logic       taken;
  logic       flag_v, flag_n, flag_c, flag_z;

  assign fsm_state = state;
  assign {flag_v, flag_n, flag_c, flag_z} = flags_in;

  always_comb begin
    imm_src   = (ir[5:4] == 2'b01) || ((ir[5:4] == 2'b11) && (ir[11:8] == 4'd0));
    ext_words = 2'(imm_src) + 2'(ir[7]);
    taken     = 1'b0;
    case (ir[12:10])
      3'b000:  taken = !flag_z;
      3'b001:  taken = flag_z;
      3'b010:  taken = !flag_c;
      3'b011:  taken = flag_c;
      3'b100:  taken = flag_n;
      3'b101:  taken = (flag_n == flag_v);
      3'b110:  taken = (flag_n != flag_v);
      default: taken = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= StFetch;
      ir         <= '0;
      ext_left   <= '0;
      no_wb      <= 1'b0;
      inst_ready <= 1'b0;
      pc_inc     <= 1'b0;
      en_pc_2    <= 1'b0;
      branch_en  <= 1'b0;
      pc_offset  <= '0;
      src_reg    <= '0;
      dst_reg    <= '0;
      wr_reg     <= '0;
      wr_en      <= 1'b0;
      op_code    <= '0;
      byte_op    <= 1'b0;
      illegal    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      pc_inc    <= 1'b0;
      en_pc_2   <= 1'b0;
      branch_en <= 1'b0;
      wr_en     <= 1'b0;
      illegal   <= 1'b0;
      unique case (state)
        StFetch: begin
          if (inst_valid && inst_ready) begin
            ir         <= instruction;
            inst_ready <= 1'b0;
            pc_inc     <= 1'b1;
            en_pc_2    <= 1'b1;
            state      <= StDecode;
          end else begin
            inst_ready <= 1'b1;
          end
        end
        StDecode: begin
          if (ir[15:13] == 3'b000) begin
            illegal    <= 1'b1;
            inst_ready <= 1'b1;
            state      <= StFetch;
          end else if (ir[15:13] == 3'b001) begin
            state <= StJump;
          end else begin
            op_code  <= OPC_W'(ir[15:12] - 4'd4);
            src_reg  <= REG_AW'(ir[11:8]);
            dst_reg  <= REG_AW'(ir[3:0]);
            byte_op  <= ir[6];
            no_wb    <= (ir[15:12] == 4'h9) || (ir[15:12] == 4'hB) || ir[7];
            ext_left <= ext_words;
            if (ext_words != 2'd0) begin
              inst_ready <= 1'b1;
              state      <= StOperand;
            end else begin
              state <= StExec;
            end
          end
        end
        StOperand: begin
          if (inst_valid && inst_ready) begin
            pc_inc   <= 1'b1;
            en_pc_2  <= 1'b1;
            ext_left <= ext_left - 2'd1;
            if (ext_left == 2'd1) begin
              inst_ready <= 1'b0;
              state      <= StExec;
            end
          end
        end
        StExec: begin
          wr_reg <= dst_reg;
          wr_en  <= !no_wb;
          state  <= StWrback;
        end
        StWrback: begin
          inst_ready <= 1'b1;
          state      <= StFetch;
        end
        StJump: begin
          if (taken) begin
            branch_en <= 1'b1;
            pc_inc    <= 1'b1;
            pc_offset <= OFF_W'($signed(ir[9:0]));
          end
          inst_ready <= 1'b1;
          state      <= StFetch;
        end
        default: begin
          inst_ready <= 1'b1;
          state      <= StFetch;
        end
      endcase
    end
  end

`ifdef CU_RETIRE_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      retired_cnt <= '0;
    end else if ((state == StWrback) || (state == StJump)) begin
      retired_cnt <= retired_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_control_unit_mc.sv
// Directed bench for control_unit_mc: reset, ALU ops, extension words, jumps, illegal, reset abort.
module tb_control_unit_mc;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_valid;
  logic [15:0] instruction;
  logic [3:0]  flags_in;
  logic        inst_ready, pc_inc, en_pc_2, branch_en, wr_en, byte_op, illegal;
  logic [9:0]  pc_offset;
  logic [3:0]  src_reg, dst_reg, wr_reg;
  logic [4:0]  op_code;
  logic [5:0]  fsm_state;
`ifdef CU_RETIRE_CNT_EN
  logic [31:0] retired_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [5:0] S_FETCH = 6'b000001, S_DECODE = 6'b000010, S_OPERAND = 6'b000100,
                         S_EXEC = 6'b001000, S_WRBACK = 6'b010000, S_JUMP = 6'b100000;

  always #5 clk = ~clk;

  control_unit_mc dut (
    .clk         (clk),
    .rst         (rst),
    .inst_valid  (inst_valid),
    .instruction (instruction),
    .flags_in    (flags_in),
    .inst_ready  (inst_ready),
    .pc_inc      (pc_inc),
    .en_pc_2     (en_pc_2),
    .branch_en   (branch_en),
    .pc_offset   (pc_offset),
    .src_reg     (src_reg),
    .dst_reg     (dst_reg),
    .wr_reg      (wr_reg),
    .wr_en       (wr_en),
    .op_code     (op_code),
    .byte_op     (byte_op),
    .fsm_state   (fsm_state),
    .illegal     (illegal)
`ifdef CU_RETIRE_CNT_EN
    ,
    .retired_cnt (retired_cnt)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [15:0] w);
    inst_valid  = 1'b1;
    instruction = w;
  endtask

  initial begin
    rst = 1'b1; inst_valid = 1'b0; instruction = '0; flags_in = '0;
    step(); step();
    chk("rst_state", 32'(fsm_state), 32'(S_FETCH));
    chk("rst_ready", 32'(inst_ready), 0);
    chk("rst_outs", {pc_inc, en_pc_2, branch_en, wr_en, illegal, byte_op}, 0);
    chk("rst_fields", {pc_offset, src_reg, dst_reg, wr_reg, op_code}, 0);
    rst = 1'b0;
    step();
    chk("ready_after_rst", 32'(inst_ready), 1);

    // ADD R5,R6 with valid held throughout
    send(16'h5506);
    step();
    chk("add_decode", 32'(fsm_state), 32'(S_DECODE));
    chk("add_pcinc", {pc_inc, en_pc_2, inst_ready}, 3'b110);
    step();
    chk("add_exec", 32'(fsm_state), 32'(S_EXEC));
    chk("add_opc", {op_code, src_reg, dst_reg}, {5'd1, 4'd5, 4'd6});
    chk("add_pcinc_off", 32'(pc_inc), 0);
    step();
    chk("add_wb", {wr_en, wr_reg}, {1'b1, 4'd6});
    inst_valid = 1'b0;
    step();
    chk("add_ready4", {fsm_state, inst_ready, wr_en}, {S_FETCH, 1'b1, 1'b0});

    // MOV #imm,R4 with extension word after idle cycles
    send(16'h4034);
    step();
    chk("mov_decode", {fsm_state, pc_inc}, {S_DECODE, 1'b1});
    inst_valid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      chk("mov_operand_wait", {fsm_state, inst_ready, pc_inc}, {S_OPERAND, 1'b1, 1'b0});
      step();
    end
    send(16'h1234);
    step();
    chk("mov_ext_pcinc", {fsm_state, pc_inc, en_pc_2, inst_ready}, {S_EXEC, 3'b110});
    chk("mov_opc", {op_code, src_reg, dst_reg}, {5'd0, 4'd0, 4'd4});
    inst_valid = 1'b0;
    step();
    chk("mov_wb", {wr_en, wr_reg}, {1'b1, 4'd4});
    step();

    // JEQ -4 taken (Z=1)
    flags_in = 4'b0001;
    send(16'h27FC);
    step();
    inst_valid = 1'b0;
    step();
    chk("jeq_jump", {fsm_state, pc_inc, branch_en}, {S_JUMP, 2'b00});
    step();
    chk("jeq_taken", {branch_en, pc_inc, en_pc_2, pc_offset}, {3'b110, 10'h3FC});
    chk("jeq_ready", {fsm_state, inst_ready}, {S_FETCH, 1'b1});
    step();
    chk("jeq_pulse_end", {branch_en, pc_inc}, 2'b00);

    // JEQ not taken (Z=0)
    flags_in = 4'b0000;
    send(16'h27FC);
    step();
    inst_valid = 1'b0;
    step();
    chk("jeq_nt_jump", {fsm_state, pc_inc}, {S_JUMP, 1'b0});
    step();
    chk("jeq_not_taken", {branch_en, pc_inc, fsm_state}, {2'b00, S_FETCH});

    // JL offset 0, N=1 V=0 -> taken
    flags_in = 4'b0100;
    send(16'h3800);
    step();
    inst_valid = 1'b0;
    step(); step();
    chk("jl_taken", {branch_en, pc_inc, pc_offset}, {2'b11, 10'h000});
    flags_in = 4'b0000;

    // CMP R1,R2: no write-back
    send(16'h9102);
    step();
    inst_valid = 1'b0;
    step();
    chk("cmp_exec", {op_code, src_reg, dst_reg}, {5'd5, 4'd1, 4'd2});
    step();
    chk("cmp_wb", {fsm_state, wr_en, wr_reg}, {S_WRBACK, 1'b0, 4'd2});
    step();

    // ADD R5,&dst (Ad=1): one extension word, memory destination, no write
    send(16'h55C6);
    step();
    step();
    chk("addm_operand", 32'(fsm_state), 32'(S_OPERAND));
    send(16'hBEEF);
    step();
    chk("addm_exec", {fsm_state, byte_op, pc_inc}, {S_EXEC, 1'b1, 1'b1});
    inst_valid = 1'b0;
    step();
    chk("addm_no_wr", {fsm_state, wr_en}, {S_WRBACK, 1'b0});
    step();

    // Illegal word
    send(16'h0123);
    step();
    inst_valid = 1'b0;
    step();
    chk("illegal_pulse", {illegal, fsm_state, inst_ready}, {1'b1, S_FETCH, 1'b1});
    step();
    chk("illegal_end", 32'(illegal), 0);
`ifdef CU_RETIRE_CNT_EN
    chk("retired_cnt", retired_cnt, 32'd7);
`endif

    // Reset held two cycles mid-OPERAND, then a fresh instruction
    send(16'h4034);
    step();
    inst_valid = 1'b0;
    step();
    chk("pre_abort_operand", 32'(fsm_state), 32'(S_OPERAND));
    rst = 1'b1;
    step(); step();
    chk("abort_state", {fsm_state, inst_ready}, {S_FETCH, 1'b0});
    chk("abort_outs", {pc_offset, src_reg, dst_reg, wr_reg, op_code, pc_inc, wr_en}, 0);
`ifdef CU_RETIRE_CNT_EN
    chk("retired_rst", retired_cnt, 0);
`endif
    rst = 1'b0;
    step();
    send(16'h5506);
    step();
    chk("fresh_decode", 32'(fsm_state), 32'(S_DECODE));
    inst_valid = 1'b0;
    step();
    chk("fresh_exec", {fsm_state, op_code, dst_reg}, {S_EXEC, 5'd1, 4'd6});
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
